alu_pipe: RTL and testbench

Parametrised, registered ALU with a valid/ready handshake on both sides. It replaces the purely combinational 4-op ALU. Adds XOR, shifts, signed/unsigned compare and an optional iterative multiplier. Flags are computed per opcode and registered alongside the result. Sits between the decode/issue stage and writeback: upstream drives operands, and a downstream consumer may stall it.

---
 rtl/alu_pipe.sv | 190 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops issue back to back,
// MUL runs an iterative shift-add over WIDTH cycles.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_fz,
  output logic             out_fc,
  output logic             out_fn,
  output logic             out_fv,
  output logic             out_err,
  output logic [1:0]       dbg_state_o
);
  // Handshake: a transfer occurs on a rising edge with valid && ready on that side;
  // ready never depends on valid, and a stalled output holds all fields stable.
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_OUT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             fz_q, fz_d, fc_q, fc_d, fn_q, fn_d, fv_q, fv_d, err_q, err_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]   add_ext;
  logic [WIDTH-1:0] sub_res;
  logic [SHW-1:0]   sh;
  logic             is_mul, accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  assign add_ext  = {1'b0, in_a} + {1'b0, in_b};
  assign sub_res  = in_a - in_b;
  assign sh       = in_b[SHW-1:0];
  assign is_mul   = MUL_EN && (in_op == OP_MUL);
  assign in_ready = (state_q != S_MUL) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Multiplier bits shift out of b_q LSB-first; the product forms in {acc_hi, acc_lo}.
  assign mul_sum = {1'b0, acc_hi_q} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_ext[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_c   = in_a < in_b;
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLL:  alu_res = in_a << sh;
      OP_SRL:  alu_res = in_a >> sh;
      OP_SRA:  alu_res = $signed(in_a) >>> sh;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    res_d    = res_q;
    fz_d     = fz_q;
    fc_d     = fc_q;
    fn_d     = fn_q;
    fv_d     = fv_q;
    err_d    = err_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_OUT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
        if (accept) begin
          if (is_mul) begin
            a_d      = in_a;
            b_d      = in_b;
            acc_hi_d = '0;
            acc_lo_d = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            valid_d = 1'b1;
            res_d   = alu_res;
            fz_d    = (alu_res == '0);
            fn_d    = alu_res[WIDTH-1];
            fc_d    = alu_c;
            fv_d    = alu_v;
            err_d   = alu_err;
            state_d = S_OUT;
          end
        end
      end
      S_MUL: begin
        b_d      = b_q >> 1;
        acc_hi_d = mul_hi;
        acc_lo_d = mul_lo;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          valid_d = 1'b1;
          res_d   = mul_lo;
          fz_d    = (mul_lo == '0);
          fn_d    = mul_lo[WIDTH-1];
          fc_d    = |mul_hi;
          fv_d    = 1'b0;
          err_d   = 1'b0;
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      res_q    <= '0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fn_q     <= 1'b0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
      fn_q     <= fn_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_res     = res_q;
  assign out_fz      = fz_q;
  assign out_fc      = fc_q;
  assign out_fn      = fn_q;
  assign out_fv      = fv_q;
  assign out_err     = err_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors plus randomized traffic with random backpressure,
// scored against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W  = 32;
  localparam int EW = W + 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, out_res;
  logic [3:0]   in_op;
  logic         out_fz, out_fc, out_fn, out_fv, out_err;
  logic [1:0]   dbg_state;

  logic         u1_in_valid, u1_in_ready, u1_out_valid, u1_out_ready;
  logic [W-1:0] u1_in_a, u1_in_b, u1_out_res;
  logic [3:0]   u1_in_op;
  logic         u1_fz, u1_fc, u1_fn, u1_fv, u1_err;
  logic [1:0]   u1_dbg_state;

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_fz(out_fz), .out_fc(out_fc), .out_fn(out_fn), .out_fv(out_fv),
    .out_err(out_err), .dbg_state_o(dbg_state)
  );

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
    .in_a(u1_in_a), .in_b(u1_in_b), .in_op(u1_in_op), .out_valid(u1_out_valid),
    .out_ready(u1_out_ready), .out_res(u1_out_res), .out_fz(u1_fz), .out_fc(u1_fc),
    .out_fn(u1_fn), .out_fv(u1_fv), .out_err(u1_err), .dbg_state_o(u1_dbg_state)
  );

  // Observed word: {err, v, n, c, z, res}
  logic [EW-1:0] obs, u1_obs;
  assign obs    = {out_err, out_fv, out_fn, out_fc, out_fz, out_res};
  assign u1_obs = {u1_err, u1_fv, u1_fn, u1_fc, u1_fz, u1_out_res};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  localparam longint SMAX = (longint'(1) << 31) - 1;
  localparam longint SMIN = -(longint'(1) << 31);

  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input bit mul_en);
    longint unsigned ua, ub, p;
    longint sa, sb, s;
    logic [W-1:0] r;
    bit c, v, err;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = '0; c = 0; v = 0; err = 0; p = 0; s = 0;
    case (op)
      4'd0: begin p = ua + ub; r = p[31:0]; c = p[32]; s = sa + sb; v = (s > SMAX) || (s < SMIN); end
      4'd1: begin r = a - b; c = (ua < ub); s = sa - sb; v = (s > SMAX) || (s < SMIN); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: begin s = sa >>> b[4:0]; r = s[31:0]; end
      4'd8: r = {31'b0, (sa < sb)};
      4'd9: r = {31'b0, (ua < ub)};
      4'd10: begin
        if (mul_en) begin p = ua * ub; r = p[31:0]; c = (p[63:32] != 0); end
        else err = 1;
      end
      default: err = 1;
    endcase
    if (err) begin r = '0; c = 0; v = 0; end
    return {err, v, r[W-1], c, (r == 0), r};
  endfunction

  // Scoreboard: accepts push model results, every valid output is compared to the head.
  logic [EW-1:0] exp_q[$];
  bit mon_en = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
        else begin
          check("scoreboard", 64'(obs), 64'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b, 1'b1));
    end
  end

  bit rand_rdy = 0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("issue_wait", 64'(n >= 200), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 4'($urandom_range(0, 15)); in_a = $urandom; in_b = $urandom;
  endtask

  task automatic wait_mul(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 100) begin
      check({tag, "_ready_low"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'd32);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    int seen, n;
    logic [3:0] op;
    rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 1;
    u1_in_valid = 0; u1_in_a = 0; u1_in_b = 0; u1_in_op = 0; u1_out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_obs", 64'(obs), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_dbg_state", 64'(dbg_state), 64'd0);
    mon_en = 1;
    @(posedge clk); #1;

    issue(4'd0, 32'hFFFF_FFFF, 32'h1);
    check("add_latency", 64'(out_valid), 64'd1);
    check("add_vec", 64'(obs), 64'({5'b00011, 32'h0}));
    issue(4'd1, 32'h8000_0000, 32'h1);
    check("sub_vec", 64'(obs), 64'({5'b01000, 32'h7FFF_FFFF}));
    issue(4'd7, 32'h8000_0000, 32'h4);
    check("sra_vec", 64'(obs), 64'({5'b00100, 32'hF800_0000}));
    issue(4'd8, 32'hFFFF_FFFF, 32'h1);
    check("slt_vec", 64'(obs), 64'({5'b00000, 32'h1}));
    issue(4'd9, 32'hFFFF_FFFF, 32'h1);
    check("sltu_vec", 64'(obs), 64'({5'b00001, 32'h0}));

    t0 = $time;
    for (int i = 0; i < 4; i++) issue(4'd4, $urandom, $urandom);
    check("b2b_cycles", 64'(($time - t0) / 10), 64'd4);

    issue(4'd10, 32'h0001_0000, 32'h0001_0000);
    wait_mul("mul_big");
    check("mul_big_vec", 64'(obs), 64'({5'b00011, 32'h0}));
    issue(4'd10, 32'd7, 32'd6);
    wait_mul("mul_small");
    check("mul_small_vec", 64'(obs), 64'({5'b00000, 32'd42}));

    @(posedge clk); #1;
    out_ready = 0;
    issue(4'd0, 32'd1, 32'd2);
    in_valid = 1; in_op = 4'd3; in_a = 32'hF0; in_b = 32'h0F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold", 64'(obs), 64'({5'b00000, 32'd3}));
    end
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 0;
    check("bp_or_vec", 64'(obs), 64'({5'b00000, 32'hFF}));

    issue(4'hF, 32'd5, 32'd5);
    check("illegal_vec", 64'(obs), 64'({5'b10001, 32'h0}));
    u1_in_valid = 1; u1_in_op = 4'd10; u1_in_a = 32'd7; u1_in_b = 32'd6;
    @(negedge clk);
    check("nomul_ready", 64'(u1_in_ready), 64'd1);
    @(posedge clk); #1 u1_in_valid = 0;
    check("nomul_valid", 64'(u1_out_valid), 64'd1);
    check("nomul_vec", 64'(u1_obs), 64'({5'b10001, 32'h0}));

    issue(4'd10, $urandom, $urandom);
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    check("rst_mul_valid", 64'(out_valid), 64'd0);
    check("rst_mul_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_mul_no_result", 64'(seen), 64'd0);
    @(posedge clk); #1;

    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op = 4'($urandom_range(0, 15));
      if (op == 4'd10 && $urandom_range(0, 1) == 0) op = 4'd0;
      issue(op, pick(), pick());
    end
    rand_rdy = 0;
    @(posedge clk); #2 out_ready = 1;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
